// File: rtl/bit_pattern_detector_pkg.sv
`default_nettype none
// ============================================================================
// Module : bitdet_pkg
// Brief  : Shared defaults and sizing helper for the bit pattern detector.
// Rev    : 1.0
// ============================================================================
package bitdet_pkg;

    localparam int         DEFAULT_N     = 4;
    localparam int         DEFAULT_CNT_W = 8;
    localparam logic [3:0] PATTERN_1011  = 4'b1011;

    // Bits needed to hold values 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bit_pattern_detector_sat_counter.sv
`default_nettype none
// ============================================================================
// Module : sat_counter
// Brief  : Up-counter that sticks at all-ones; clear has priority over inc.
// Rev    : 1.0
// ============================================================================
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && (r_q != {W{1'b1}})) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/bit_pattern_detector.sv
`default_nettype none
// ============================================================================
// Module : bit_pattern_detector
// Brief  : Flags each occurrence of PATTERN in a qualified serial bit stream.
// Rev    : 1.0
// ============================================================================
module bit_pattern_detector
    import bitdet_pkg::*;
#(
    parameter int           N       = DEFAULT_N,
    parameter logic [N-1:0] PATTERN = N'(PATTERN_1011),
    parameter int           OVERLAP = 1,
    parameter int           CNT_W   = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clr_cnt,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             primed
);

    localparam int                FILL_W    = clog2(N + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N);

    logic [N-1:0]      r_hist;
    logic [FILL_W-1:0] r_fill;
    logic              r_match;

    logic [N-1:0]      w_hist_next;
    logic [FILL_W-1:0] w_fill_next;
    logic              w_hit;

    assign w_hist_next = {r_hist[N-2:0], din};
    assign w_fill_next = (r_fill == FILL_FULL) ? FILL_FULL : r_fill + 1'b1;
    assign w_hit       = din_valid && (w_fill_next == FILL_FULL) && (w_hist_next == PATTERN);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist  <= '0;
            r_fill  <= '0;
            r_match <= 1'b0;
        end else begin
            r_match <= w_hit;
            // Gaps (din_valid low) leave the history untouched.
            if (din_valid) begin
                if (w_hit && (OVERLAP == 0)) begin
                    r_hist <= '0;
                    r_fill <= '0;
                end else begin
                    r_hist <= w_hist_next;
                    r_fill <= w_fill_next;
                end
            end
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_hit),
        .clr (clr_cnt),
        .q   (match_count)
    );

    assign match  = r_match;
    assign primed = (r_fill == FILL_FULL);

endmodule
`default_nettype wire

// File: tb/tb_bit_pattern_detector.sv
`default_nettype none
// ============================================================================
// Module : tb_bit_pattern_detector
// Brief  : Four detector configurations on one shared stream, checked against
//          a window-of-bits model plus literal expectations.
// Rev    : 1.0
// ============================================================================
module tb_bit_pattern_detector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, din = 1'b0, din_valid = 1'b0, clr_cnt = 1'b0;

    logic       match0, match1, match2, match3;
    logic       primed0, primed1, primed2, primed3;
    logic [7:0] count0, count1, count3;
    logic [1:0] count2;

    // 0: 1011 overlap, 1: 1011 non-overlap, 2: 1011 overlap 2-bit count, 3: 1111 overlap
    bit_pattern_detector #(.N(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
        .match(match0), .match_count(count0), .primed(primed0));
    bit_pattern_detector #(.N(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
        .match(match1), .match_count(count1), .primed(primed1));
    bit_pattern_detector #(.N(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
        .match(match2), .match_count(count2), .primed(primed2));
    bit_pattern_detector #(.N(4), .PATTERN(4'b1111), .OVERLAP(1), .CNT_W(8)) dut3 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
        .match(match3), .match_count(count3), .primed(primed3));

    logic       act_match [4];
    logic       act_primed[4];
    logic [7:0] act_cnt   [4];
    assign act_match[0] = match0;  assign act_match[1] = match1;
    assign act_match[2] = match2;  assign act_match[3] = match3;
    assign act_primed[0] = primed0; assign act_primed[1] = primed1;
    assign act_primed[2] = primed2; assign act_primed[3] = primed3;
    assign act_cnt[0] = count0;    assign act_cnt[1] = count1;
    assign act_cnt[2] = {6'b0, count2}; assign act_cnt[3] = count3;

    // Model: the list of valid bits taken since the last restart.
    int         cfg_ov [4] = '{1, 0, 1, 1};
    int         cfg_max[4] = '{255, 255, 3, 255};
    logic [3:0] cfg_pat[4] = '{4'b1011, 4'b1011, 4'b1011, 4'b1111};
    bit         mb   [4][32];
    int         mlen [4];
    int         mcnt [4];
    bit         mmatch[4];

    int vectors = 0;
    int errors  = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input bit r, input bit d, input bit v, input bit c);
        bit hit;
        for (int k = 0; k < 4; k++) begin
            if (r) begin
                mlen[k] = 0; mcnt[k] = 0; mmatch[k] = 1'b0;
            end else begin
                hit = 1'b0;
                if (v) begin
                    if (mlen[k] == 32) begin
                        for (int i = 0; i < 31; i++) mb[k][i] = mb[k][i+1];
                        mlen[k] = 31;
                    end
                    mb[k][mlen[k]] = d;
                    mlen[k]++;
                    if (mlen[k] >= 4) begin
                        hit = 1'b1;
                        for (int i = 0; i < 4; i++)
                            if (mb[k][mlen[k]-4+i] != cfg_pat[k][3-i]) hit = 1'b0;
                    end
                end
                mmatch[k] = hit;
                if (hit) begin
                    if (cfg_ov[k] == 0) mlen[k] = 0;
                    if (mcnt[k] < cfg_max[k]) mcnt[k]++;
                end
                if (c) mcnt[k] = 0;
            end
        end
    endtask

    task automatic step(input bit r, input bit d, input bit v, input bit c);
        rst = r; din = d; din_valid = v; clr_cnt = c;
        @(posedge clk);
        model_update(r, d, v, c);
        #1;
    endtask

    task automatic bit_in(input bit d);
        step(1'b0, d, 1'b1, 1'b0);
    endtask

    task automatic gap();
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (checking) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("match[%0d]", k),  int'(act_match[k]),  int'(mmatch[k]));
                chk($sformatf("count[%0d]", k),  int'(act_cnt[k]),    mcnt[k]);
                chk($sformatf("primed[%0d]", k), int'(act_primed[k]), int'(mlen[k] >= 4));
            end
        end
    end

    initial begin
        do_reset();
        do_reset();
        chk("reset_match0", int'(match0), 0);
        chk("reset_count0", int'(count0), 0);
        chk("reset_primed0", int'(primed0), 0);
        checking = 1'b1;

        // 1,0,1,1 then 0,1,1
        bit_in(1); bit_in(0); bit_in(1);
        chk("pre_match0", int'(match0), 0);
        bit_in(1);
        chk("first_match0", int'(match0), 1);
        chk("first_count0", int'(count0), 1);
        chk("first_primed0", int'(primed0), 1);
        bit_in(0);
        chk("pulse_drop0", int'(match0), 0);
        bit_in(1); bit_in(1);
        chk("overlap_count0", int'(count0), 2);
        chk("nonoverlap_count1", int'(count1), 1);
        chk("nonoverlap_match1", int'(match1), 0);

        // Gaps never break a sequence.
        do_reset();
        bit_in(1); gap(); gap(); gap(); bit_in(0); bit_in(1); gap();
        chk("gap_nopulse0", int'(match0), 0);
        bit_in(1);
        chk("gap_match0", int'(match0), 1);
        chk("gap_count0", int'(count0), 1);

        // Reset mid-sequence discards partial history.
        do_reset();
        bit_in(1); bit_in(0); bit_in(1);
        do_reset();
        bit_in(1);
        chk("midrst_match0", int'(match0), 0);
        chk("midrst_primed0", int'(primed0), 0);

        // Saturation of the 2-bit counter, then clear colliding with a hit.
        do_reset();
        for (int n = 0; n < 4; n++) begin
            bit_in(1); bit_in(0); bit_in(1); bit_in(1);
            chk("sat_match2", int'(match2), 1);
            chk("sat_count2", int'(count2), (n < 3) ? n + 1 : 3);
        end
        bit_in(1); bit_in(0); bit_in(1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("clr_hit_match2", int'(match2), 1);
        chk("clr_hit_count2", int'(count2), 0);

        // All-ones pattern with overlap: six ones give three hits in a row.
        do_reset();
        for (int n = 0; n < 6; n++) begin
            bit_in(1);
            if (n >= 3) chk("ones_match3", int'(match3), 1);
        end
        chk("ones_count3", int'(count3), 3);
        chk("ones_count0", int'(count0), 0);

        // Pseudo-random stream with occasional gaps and clears, model only.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));
        end

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
